// File: rtl/msgpass_addr_gen_mc_pkg.sv
// -----------------------------------------------------------------------------
// msgPass_config_pkg
// Shared configuration for the message-passing address generator:
//   - default geometry constants (address width, depth, channel count,
//     number of increment sources, layer-length width)
//   - INC_SEL_WIDTH for the default number of increment sources
//   - the generator FSM state enum
// No ports (package).
// -----------------------------------------------------------------------------
package msgPass_config_pkg;

  localparam int DEF_ADDR_WIDTH  = 7;
  localparam int DEF_DEPTH       = 2 ** DEF_ADDR_WIDTH;
  localparam int DEF_CH_NUM      = 2;
  localparam int DEF_INC_SRC_NUM = 3;
  localparam int DEF_LEN_WIDTH   = 8;
  localparam int INC_SEL_WIDTH   = $clog2(DEF_INC_SRC_NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/msgpass_addr_wrap_add.sv
// -----------------------------------------------------------------------------
// msgpass_addr_wrap_add
// Combinational modular adder for one address channel:
//   sum = (addr + step) - DEPTH  when addr + step >= DEPTH
//   sum =  addr + step           otherwise
// The raw sum is formed one bit wider than the address so the carry is kept
// for the compare; DEPTH need not be a power of two.
// Ports:
//   addr  in  ADDR_WIDTH  current address (expected < DEPTH)
//   step  in  ADDR_WIDTH  increment (expected < DEPTH)
//   sum   out ADDR_WIDTH  wrapped next address
// -----------------------------------------------------------------------------
module msgpass_addr_wrap_add #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] step,
  output logic [ADDR_WIDTH-1:0] sum
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH:0] raw;

  always_comb begin
    raw = {1'b0, addr} + {1'b0, step};
    sum = ADDR_WIDTH'((raw >= DEPTH_W) ? (raw - DEPTH_W) : raw);
  end

endmodule

// File: rtl/msgpass_addr_gen_mc.sv
// -----------------------------------------------------------------------------
// msgpass_addr_gen_mc
// Multi-channel address generator for one message-passing layer. A start in
// IDLE loads per-channel base addresses and a layer length; the block then
// issues layer_len address sets, each channel advancing by the selected
// increment modulo DEPTH, and pulses layer_done once at the end.
//
// Handshake: an address set transfers on a rising edge where
// addr_valid && addr_ready. addr_valid is registered and stays high until the
// final transfer; while addr_ready is low, addr_out, addr_valid and the issue
// counter hold. inc_sel is sampled only on transfer edges.
//
// Optional build: define MSGPASS_ADDR_ERR_CHK_EN to enable the sticky err flag
// (set by a start outside IDLE, a zero-length start, or a transfer whose
// selected source is out of range or whose step is >= DEPTH). Without it err
// is tied low.
//
// Ports:
//   sys_clk     in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   request a layer (honoured only in IDLE)
//   base_addr   in   CH_NUM x ADDR_WIDTH start addresses
//   layer_len   in   LEN_WIDTH address sets to issue
//   inc_val     in   INC_SRC_NUM x ADDR_WIDTH candidate steps
//   inc_sel     in   step source select (out of range -> step 0)
//   addr_ready  in   consumer accepts addr_out
//   addr_out    out  CH_NUM x ADDR_WIDTH current addresses
//   addr_valid  out  addr_out valid
//   busy        out  state is not IDLE
//   layer_done  out  one-cycle pulse in the DONE state
//   err         out  sticky error flag
//   state_dbg   out  current FSM state
// -----------------------------------------------------------------------------
module msgpass_addr_gen_mc
  import msgPass_config_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH       = 2 ** ADDR_WIDTH,
  parameter int CH_NUM      = DEF_CH_NUM,
  parameter int INC_SRC_NUM = DEF_INC_SRC_NUM,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
  localparam int SEL_W      = (INC_SRC_NUM > 1) ? $clog2(INC_SRC_NUM) : 1
) (
  input  logic                                 sys_clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CH_NUM-1:0][ADDR_WIDTH-1:0]    base_addr,
  input  logic [LEN_WIDTH-1:0]                 layer_len,
  input  logic [INC_SRC_NUM-1:0][ADDR_WIDTH-1:0] inc_val,
  input  logic [SEL_W-1:0]                     inc_sel,
  input  logic                                 addr_ready,
  output logic [CH_NUM-1:0][ADDR_WIDTH-1:0]    addr_out,
  output logic                                 addr_valid,
  output logic                                 busy,
  output logic                                 layer_done,
  output logic                                 err,
  output state_t                               state_dbg
);

  state_t                            state;
  logic [LEN_WIDTH-1:0]              cnt;
  logic [LEN_WIDTH-1:0]              len_q;
  logic [ADDR_WIDTH-1:0]             step;
  logic [CH_NUM-1:0][ADDR_WIDTH-1:0] next_addr;
  logic                              hs;
  logic                              last;

  assign hs        = addr_valid && addr_ready;
  assign last      = (cnt == (len_q - LEN_WIDTH'(1)));
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Explicit compare-mux so an out-of-range select falls through to zero
  // instead of indexing past the array.
  always_comb begin
    step = '0;
    for (int i = 0; i < INC_SRC_NUM; i++) begin
      if (inc_sel == SEL_W'(i)) step = inc_val[i];
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    msgpass_addr_wrap_add #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_wrap_add (
      .addr (addr_out[c]),
      .step (step),
      .sum  (next_addr[c])
    );
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      layer_done <= 1'b0;
      cnt        <= '0;
      len_q      <= '0;
    end else begin
      layer_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= layer_len;
            cnt   <= '0;
            if (layer_len != '0) begin
              state      <= RUN;
              addr_out   <= base_addr;
              addr_valid <= 1'b1;
            end else begin
              // Empty layer: nothing to issue, go straight to the done pulse.
              state      <= DONE;
              layer_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            if (last) begin
              state      <= DONE;
              addr_valid <= 1'b0;
              layer_done <= 1'b1;
            end else begin
              addr_out <= next_addr;
              cnt      <= cnt + LEN_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MSGPASS_ADDR_ERR_CHK_EN
  logic bad_sel;
  logic big_step;
  logic err_q;

  assign bad_sel  = ({1'b0, inc_sel} >= (SEL_W + 1)'(INC_SRC_NUM));
  assign big_step = ({1'b0, step} >= (ADDR_WIDTH + 1)'(DEPTH));
  assign err      = err_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((start && (state != IDLE)) ||
                 (start && (state == IDLE) && (layer_len == '0)) ||
                 (hs && (bad_sel || big_step))) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_msgpass_addr_gen_mc.sv
// -----------------------------------------------------------------------------
// tb_msgpass_addr_gen_mc
// Two instances share all inputs: one with DEPTH=128 (default) and one with
// DEPTH=100 (non-power-of-two wrap). Each layer is checked against a modulo
// arithmetic reference kept per instance.
// -----------------------------------------------------------------------------
module tb_msgpass_addr_gen_mc;
  import msgPass_config_pkg::*;

`ifdef MSGPASS_ADDR_ERR_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic            sys_clk;
  logic            rst;
  logic            start;
  logic [1:0][6:0] base_addr;
  logic [7:0]      layer_len;
  logic [2:0][6:0] inc_val;
  logic [1:0]      inc_sel;
  logic            addr_ready;

  logic [1:0][6:0] addr_o  [2];
  logic            valid_o [2];
  logic            busy_o  [2];
  logic            done_o  [2];
  logic            err_o   [2];
  state_t          st_o    [2];

  int depth_of [2] = '{128, 100};
  int n_checks = 0;
  int n_fail   = 0;
  bit exp_err  = 1'b0;

  msgpass_addr_gen_mc dut_a (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .layer_len  (layer_len),
    .inc_val    (inc_val),
    .inc_sel    (inc_sel),
    .addr_ready (addr_ready),
    .addr_out   (addr_o[0]),
    .addr_valid (valid_o[0]),
    .busy       (busy_o[0]),
    .layer_done (done_o[0]),
    .err        (err_o[0]),
    .state_dbg  (st_o[0])
  );

  msgpass_addr_gen_mc #(.DEPTH(100)) dut_b (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .layer_len  (layer_len),
    .inc_val    (inc_val),
    .inc_sel    (inc_sel),
    .addr_ready (addr_ready),
    .addr_out   (addr_o[1]),
    .addr_valid (valid_o[1]),
    .busy       (busy_o[1]),
    .layer_done (done_o[1]),
    .err        (err_o[1]),
    .state_dbg  (st_o[1])
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one layer and checks every cycle of it on both instances.
  // sel_mode < 0 picks a random select (0..3) each cycle; ready_mode
  // 0 = always ready, 1 = random, 2 = low for the first 3 cycles.
  task automatic run_layer(input int b0, input int b1, input int len,
                           input int sel_mode, input int ready_mode,
                           input int poke_at);
    int cur [2][2];
    int issued;
    int cyc;
    int sel;
    int step;
    bit rdy;
    @(negedge sys_clk);
    base_addr[0] = 7'(b0);
    base_addr[1] = 7'(b1);
    layer_len    = 8'(len);
    start        = 1'b1;
    addr_ready   = 1'b0;
    if (CHK_EN && len == 0) exp_err = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cur[d][0] = b0;
      cur[d][1] = b1;
    end
    issued = 0;
    cyc    = 0;
    if (len == 0) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (valid_o[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL zero_len_valid dut%0d: got %0b expected 0", d, valid_o[d]);
        end
        n_checks++;
        if (done_o[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL zero_len_done dut%0d: got %0b expected 1", d, done_o[d]);
        end
      end
    end else begin
      while (issued < len && cyc < len * 8 + 20) begin
        for (int d = 0; d < 2; d++) begin
          n_checks++;
          if (valid_o[d] !== 1'b1 || busy_o[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL run_valid_busy dut%0d cyc%0d: got valid=%0b busy=%0b expected 1/1",
                     d, cyc, valid_o[d], busy_o[d]);
          end
          for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (addr_o[d][c] !== 7'(cur[d][c])) begin
              n_fail++;
              $display("FAIL addr dut%0d ch%0d issue%0d: got %0d expected %0d",
                       d, c, issued, addr_o[d][c], cur[d][c]);
            end
          end
        end
        sel = (sel_mode < 0) ? int'($urandom_range(0, 3)) : sel_mode;
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom_range(0, 2) != 0);
          default: rdy = (cyc >= 3);
        endcase
        if (cyc == poke_at) begin
          start = 1'b1;
          if (CHK_EN) exp_err = 1'b1;
        end else begin
          start = 1'b0;
        end
        addr_ready = rdy;
        inc_sel    = 2'(sel);
        if (rdy) begin
          step = (sel < 3) ? int'(inc_val[sel]) : 0;
          if (CHK_EN && sel >= 3) exp_err = 1'b1;
          for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++)
              cur[d][c] = (cur[d][c] + step) % depth_of[d];
          issued++;
        end
        cyc++;
        @(negedge sys_clk);
      end
      start      = 1'b0;
      addr_ready = 1'b0;
      if (issued < len) begin
        n_checks++;
        n_fail++;
        $display("FAIL layer_timeout: issued %0d expected %0d", issued, len);
      end
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (valid_o[d] !== 1'b0 || done_o[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL end_of_layer dut%0d: got valid=%0b done=%0b expected 0/1",
                   d, valid_o[d], done_o[d]);
        end
      end
    end
    @(negedge sys_clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (done_o[d] !== 1'b0 || busy_o[d] !== 1'b0 || valid_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL back_to_idle dut%0d: got done=%0b busy=%0b valid=%0b expected 0/0/0",
                 d, done_o[d], busy_o[d], valid_o[d]);
      end
      n_checks++;
      if (err_o[d] !== exp_err) begin
        n_fail++;
        $display("FAIL err_flag dut%0d: got %0b expected %0b", d, err_o[d], exp_err);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; layer_len = '0;
    inc_val = '0; inc_sel = '0; addr_ready = 1'b0;
    @(negedge sys_clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (addr_o[d] !== '0 || valid_o[d] !== 1'b0 || busy_o[d] !== 1'b0 ||
          done_o[d] !== 1'b0 || err_o[d] !== 1'b0 || st_o[d] !== IDLE) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got addr=%0h v=%0b b=%0b d=%0b e=%0b st=%0d expected all 0",
                 d, addr_o[d], valid_o[d], busy_o[d], done_o[d], err_o[d], st_o[d]);
      end
    end
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic test_basic_seq();
    inc_val = '0;
    inc_val[0] = 7'd5;
    run_layer(0, 10, 4, 0, 0, -1);
  endtask

  task automatic test_wrap();
    inc_val = '0;
    inc_val[0] = 7'd7;
    run_layer(95, 50, 3, 0, 0, -1);
  endtask

  task automatic test_stall();
    inc_val = '0;
    inc_val[1] = 7'd11;
    run_layer(30, 90, 4, 1, 2, -1);
  endtask

  task automatic test_zero_len();
    run_layer(12, 34, 0, 0, 0, -1);
  endtask

  task automatic test_bad_sel();
    inc_val[0] = 7'd7; inc_val[1] = 7'd8; inc_val[2] = 7'd9;
    run_layer(5, 6, 3, 3, 0, -1);
  endtask

  task automatic test_start_ignored();
    inc_val[0] = 7'd4;
    run_layer(40, 41, 5, 0, 0, 1);
  endtask

  task automatic test_reset_mid_layer();
    inc_val[0] = 7'd3;
    @(negedge sys_clk);
    base_addr[0] = 7'd20; base_addr[1] = 7'd40; layer_len = 8'd6; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; addr_ready = 1'b1; inc_sel = 2'd0;
    @(negedge sys_clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (addr_o[d][0] !== 7'd23 || addr_o[d][1] !== 7'd43) begin
        n_fail++;
        $display("FAIL second_addr dut%0d: got %0d,%0d expected 23,43",
                 d, addr_o[d][0], addr_o[d][1]);
      end
    end
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (addr_o[d] !== '0 || valid_o[d] !== 1'b0 || busy_o[d] !== 1'b0 ||
          done_o[d] !== 1'b0 || err_o[d] !== 1'b0 || st_o[d] !== IDLE) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got addr=%0h v=%0b b=%0b d=%0b e=%0b expected all 0",
                 d, addr_o[d], valid_o[d], busy_o[d], done_o[d], err_o[d]);
      end
    end
    exp_err = 1'b0;
    @(negedge sys_clk);
    rst = 1'b0; addr_ready = 1'b0;
    run_layer(60, 70, 3, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 3; i++) inc_val[i] = 7'($urandom_range(0, 99));
      run_layer(int'($urandom_range(0, 99)), int'($urandom_range(0, 99)),
                int'($urandom_range(1, 10)), -1, 1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_seq();
    test_wrap();
    test_stall();
    test_zero_len();
    test_bad_sel();
    test_start_ignored();
    test_reset_mid_layer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
